// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register.
// Holds the mode encoding used by the RTL and by the benches.
package shift_register_pkg;

    localparam int MODE_W = 3;
    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD  = 3'b000;
    localparam mode_t MODE_SHL   = 3'b001;
    localparam mode_t MODE_SHR   = 3'b010;
    localparam mode_t MODE_ROL   = 3'b011;
    localparam mode_t MODE_ROR   = 3'b100;
    localparam mode_t MODE_LOAD  = 3'b101;
    localparam mode_t MODE_CLEAR = 3'b110;
    // 3'b111 is reserved and behaves as HOLD.

    // True for the four modes that move bits and advance the word counter.
    function automatic logic is_shift_op(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_register_univ_if.sv
// Control/data bundle for shift_register_univ.
//   en, mode, ser_in_lsb, ser_in_msb, par_in : driven by the master
//   par_out, ser_out_msb, ser_out_lsb,
//   shift_cnt, word_done                     : driven by the shift register
interface shift_register_univ_if #(
    parameter int WIDTH = 8
);
    import shift_register_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic              en;
    mode_t             mode;
    logic              ser_in_lsb;
    logic              ser_in_msb;
    logic [WIDTH-1:0]  par_in;
    logic [WIDTH-1:0]  par_out;
    logic              ser_out_msb;
    logic              ser_out_lsb;
    logic [CNT_W-1:0]  shift_cnt;
    logic              word_done;

    modport master (
        output en, mode, ser_in_lsb, ser_in_msb, par_in,
        input  par_out, ser_out_msb, ser_out_lsb, shift_cnt, word_done
    );

    modport slave (
        input  en, mode, ser_in_lsb, ser_in_msb, par_in,
        output par_out, ser_out_msb, ser_out_lsb, shift_cnt, word_done
    );

endinterface

// File: rtl/shift_word_counter.sv
// Counts shift operations within a word and pulses done for one cycle
// after WIDTH of them have completed.
//   clk, reset_n : clock, async active-low reset
//   shift_op     : a shift/rotate happens this edge
//   restart      : LOAD/CLEAR this edge, forces the count back to 0
//   cnt          : shifts since last restart or wrap
//   done         : registered one-cycle wrap pulse
module shift_word_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_op,
    input  logic             restart,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (restart) begin
            // Restart wins even on the edge that would have wrapped.
            cnt  <= '0;
            done <= 1'b0;
        end else if (shift_op) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_register_univ.sv
// Universal WIDTH-bit shift register: shift left/right with serial fill,
// rotate left/right, parallel load, synchronous clear, plus a word counter.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : en/mode/serial and parallel inputs; par_out, serial
//                  taps, shift_cnt and word_done outputs
module shift_register_univ
    import shift_register_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    shift_register_univ_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q, q_nxt;
    logic             shift_op, restart;
    logic [CNT_W-1:0] cnt;
    logic             done;

    always_comb begin
        q_nxt = q;
        if (bus.en) begin
            case (bus.mode)
                MODE_SHL:   q_nxt = {q[WIDTH-2:0], bus.ser_in_lsb};
                MODE_SHR:   q_nxt = {bus.ser_in_msb, q[WIDTH-1:1]};
                MODE_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
                MODE_LOAD:  q_nxt = bus.par_in;
                MODE_CLEAR: q_nxt = RESET_VAL;
                default:    q_nxt = q;   // HOLD and reserved
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= RESET_VAL;
        else          q <= q_nxt;
    end

    assign shift_op = bus.en && is_shift_op(bus.mode);
    assign restart  = bus.en && ((bus.mode == MODE_LOAD) || (bus.mode == MODE_CLEAR));

    shift_word_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_op (shift_op),
        .restart  (restart),
        .cnt      (cnt),
        .done     (done)
    );

    assign bus.par_out     = q;
    assign bus.ser_out_msb = q[WIDTH-1];
    assign bus.ser_out_lsb = q[0];
    assign bus.shift_cnt   = cnt;
    assign bus.word_done   = done;

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ at WIDTH=8, RESET_VAL=0.
module tb_shift_register_univ;
    import shift_register_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    shift_register_univ_if #(.WIDTH(WIDTH)) bus ();

    shift_register_univ #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operation, clock it, sample 1 time unit after the edge.
    task automatic step(input logic en, input mode_t m, input logic sl,
                        input logic sm, input logic [WIDTH-1:0] pin);
        bus.en         = en;
        bus.mode       = m;
        bus.ser_in_lsb = sl;
        bus.ser_in_msb = sm;
        bus.par_in     = pin;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] q,
                             input int cnt, input logic wd);
        check({tag, ".par_out"},   32'(bus.par_out),   32'(q));
        check({tag, ".shift_cnt"}, 32'(bus.shift_cnt), 32'(cnt));
        check({tag, ".word_done"}, 32'(bus.word_done), 32'(wd));
    endtask

    initial begin
        logic [7:0] shl_exp [5];
        logic       shl_bit [5];
        shl_exp = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16};
        shl_bit = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        bus.en = 1'b0; bus.mode = MODE_HOLD;
        bus.ser_in_lsb = 1'b0; bus.ser_in_msb = 1'b0; bus.par_in = '0;

        // Reset held across two edges.
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 8'h00, 0, 1'b0);
        check("reset.ser_out_msb", 32'(bus.ser_out_msb), 0);
        check("reset.ser_out_lsb", 32'(bus.ser_out_lsb), 0);
        reset_n = 1'b1;

        // SHL 1,0,1,1,0
        for (int i = 0; i < 5; i++) begin
            step(1'b1, MODE_SHL, shl_bit[i], 1'b0, '0);
            chk_state($sformatf("shl%0d", i), shl_exp[i], i + 1, 1'b0);
        end

        // LOAD and rotate
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
        chk_state("load_a5", 8'hA5, 0, 1'b0);
        check("load_a5.ser_out_msb", 32'(bus.ser_out_msb), 1);
        step(1'b1, MODE_ROL, 1'b0, 1'b0, '0);
        chk_state("rol", 8'h4B, 1, 1'b0);
        step(1'b1, MODE_ROR, 1'b0, 1'b0, '0);
        chk_state("ror1", 8'hA5, 2, 1'b0);
        step(1'b1, MODE_ROR, 1'b0, 1'b0, '0);
        chk_state("ror2", 8'hD2, 3, 1'b0);

        // SHR
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
        step(1'b1, MODE_SHR, 1'b0, 1'b1, '0);
        chk_state("shr1", 8'hD2, 1, 1'b0);
        check("shr1.ser_out_lsb", 32'(bus.ser_out_lsb), 0);
        step(1'b1, MODE_SHR, 1'b0, 1'b0, '0);
        chk_state("shr2", 8'h69, 2, 1'b0);
        check("shr2.ser_out_lsb", 32'(bus.ser_out_lsb), 1);

        // Word wrap: 8 SHL of ones, mixing in nothing else.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b1, MODE_SHL, 1'b1, 1'b0, '0);
        chk_state("wrap7", 8'h7F, 7, 1'b0);
        step(1'b1, MODE_SHL, 1'b1, 1'b0, '0);
        chk_state("wrap8", 8'hFF, 0, 1'b1);
        step(1'b1, MODE_SHL, 1'b1, 1'b0, '0);
        chk_state("wrap9", 8'hFF, 1, 1'b0);

        // Enable low blocks LOAD; reserved mode holds.
        step(1'b0, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
        chk_state("en0_load", 8'hFF, 1, 1'b0);
        step(1'b0, MODE_CLEAR, 1'b0, 1'b0, '0);
        chk_state("en0_clear", 8'hFF, 1, 1'b0);
        step(1'b1, mode_t'(3'b111), 1'b1, 1'b1, 8'h3C);
        chk_state("reserved", 8'hFF, 1, 1'b0);

        // Mixed directions count toward the same word; LOAD at WIDTH-1 suppresses wrap.
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, MODE_SHL, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, MODE_SHR, 1'b0, 1'b0, '0);
        chk_state("mixed7", 8'h01, 7, 1'b0);
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h5A);
        chk_state("load_at_last", 8'h5A, 0, 1'b0);
        step(1'b1, MODE_HOLD, 1'b0, 1'b0, '0);
        chk_state("hold_after_load", 8'h5A, 0, 1'b0);

        // Mixed SHL/SHR wrap
        for (int i = 0; i < 4; i++) step(1'b1, MODE_SHR, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b1, MODE_SHL, 1'b0, 1'b0, '0);
        chk_state("mixed_wrap", 8'h50, 0, 1'b1);

        // CLEAR
        step(1'b1, MODE_ROL, 1'b0, 1'b0, '0);
        step(1'b1, MODE_CLEAR, 1'b0, 1'b0, '0);
        chk_state("clear", 8'h00, 0, 1'b0);

        // Asynchronous reset mid-word, between edges.
        for (int i = 0; i < 5; i++) step(1'b1, MODE_SHL, 1'b1, 1'b0, '0);
        chk_state("pre_reset", 8'h1F, 5, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_state("async_reset", 8'h00, 0, 1'b0);
        @(posedge clk);
        #1;
        chk_state("reset_held", 8'h00, 0, 1'b0);
        reset_n = 1'b1;
        step(1'b1, MODE_SHL, 1'b1, 1'b0, '0);
        chk_state("post_reset", 8'h01, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
